// File: rtl/bus_arb_mux.sv
// bus_arb_mux: round-robin arbitrated, registered N-source bus mux with a forced-select mode
module bus_arb_mux #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ForceEn,
  input  logic [SEL_W-1:0]         ForceSel,
  input  logic [NUM_SRC-1:0]       ReqIn,
  input  logic [NUM_SRC-1:0]       LastIn,
  input  logic [NUM_SRC*WIDTH-1:0] DataIn,
  output logic [NUM_SRC-1:0]       AckOut,
  output logic [WIDTH-1:0]         BusData,
  output logic                     BusValid,
  input  logic                     BusReady,
  output logic [SEL_W-1:0]         Owner,
  output logic                     Busy
);
  typedef enum logic {IDLE, OWN} stateT;
  stateT state, nextState;
  logic [SEL_W-1:0] ptr, grantIdx, idx;
  logic grant, capture;
  assign Busy = state == OWN;
  // Arbitration in IDLE, capture/handshake in OWN; the smallest rotation offset wins the search
  always_comb begin
    grant = 1'b0;
    grantIdx = '0;
    idx = '0;
    if (ForceEn) begin
      grant = int'(ForceSel) < NUM_SRC && ReqIn[ForceSel];
      grantIdx = ForceSel;
    end else
      for (int k = NUM_SRC; k >= 1; k--) begin
        idx = SEL_W'((int'(ptr) + k) % NUM_SRC);
        if (ReqIn[idx]) begin
          grant = 1'b1;
          grantIdx = idx;
        end
      end
    if (state != IDLE) grant = 1'b0;
    capture = state == OWN && ReqIn[Owner] && (!BusValid || BusReady);
    nextState = state == IDLE ? (grant ? OWN : IDLE) : (capture && LastIn[Owner] ? IDLE : OWN);
    AckOut = capture ? NUM_SRC'(1) << Owner : '0;
  end
  // State, ownership, round-robin pointer and the output register with its valid flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      Owner <= '0;
      ptr <= SEL_W'(NUM_SRC - 1);
      BusData <= '0;
      BusValid <= 1'b0;
    end else begin
      state <= nextState;
      if (grant) Owner <= grantIdx;
      if (capture && LastIn[Owner]) ptr <= Owner;
      if (capture) BusData <= DataIn[Owner*WIDTH +: WIDTH];
      BusValid <= capture || (BusValid && !BusReady);
    end
  end
endmodule

// File: tb/tb_bus_arb_mux.sv
// tb_bus_arb_mux: directed checks of arbitration, bursts, backpressure, forced select and reset
module tb_bus_arb_mux;
  logic Clock = 1'b0, Reset = 1'b1, ForceEn = 1'b0, BusReady = 1'b1;
  logic [1:0] ForceSel = '0;
  logic [3:0] ReqIn = '0, LastIn = '0;
  logic [63:0] DataIn = '0;
  logic [3:0] AckOut;
  logic [15:0] BusData;
  logic BusValid, Busy;
  logic [1:0] Owner;
  int compared = 0, mismatched = 0;

  bus_arb_mux dut (
    .Clock(Clock), .Reset(Reset), .ForceEn(ForceEn), .ForceSel(ForceSel),
    .ReqIn(ReqIn), .LastIn(LastIn), .DataIn(DataIn), .AckOut(AckOut),
    .BusData(BusData), .BusValid(BusValid), .BusReady(BusReady),
    .Owner(Owner), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setData(input int i, input logic [15:0] v);
    DataIn[i*16 +: 16] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) setData(i, 16'hA000 + 16'(i));
    tick();
    tick();
    Reset = 1'b0;
    settle();
    chk("rst_owner", 32'(Owner), 0);
    chk("rst_valid", 32'(BusValid), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_data", 32'(BusData), 0);
    chk("rst_ack", 32'(AckOut), 0);

    ReqIn = 4'b1111;
    LastIn = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_owner", 32'(Owner), 32'(g % 4));
      chk("rr_busy_grant", 32'(Busy), 1);
      chk("rr_ack", 32'(AckOut), 32'(1 << (g % 4)));
      tick();
      chk("rr_data", 32'(BusData), 32'(16'hA000 + g % 4));
      chk("rr_valid", 32'(BusValid), 1);
      chk("rr_busy_done", 32'(Busy), 0);
      chk("rr_ack_idle", 32'(AckOut), 0);
    end
    ReqIn = 4'b0000;
    tick();
    chk("drain1_valid", 32'(BusValid), 0);

    ReqIn = 4'b0100;
    LastIn = 4'b0000;
    setData(2, 16'h00A1);
    tick();
    chk("b2_owner", 32'(Owner), 2);
    chk("b2_ack1", 32'(AckOut), 32'h4);
    tick();
    chk("b2_data1", 32'(BusData), 32'h00A1);
    chk("b2_busy1", 32'(Busy), 1);
    setData(2, 16'h00A2);
    settle();
    chk("b2_ack2", 32'(AckOut), 32'h4);
    tick();
    chk("b2_data2", 32'(BusData), 32'h00A2);
    chk("b2_valid2", 32'(BusValid), 1);
    setData(2, 16'h00A3);
    LastIn = 4'b0100;
    settle();
    chk("b2_ack3", 32'(AckOut), 32'h4);
    tick();
    chk("b2_data3", 32'(BusData), 32'h00A3);
    chk("b2_busy3", 32'(Busy), 0);
    chk("b2_ack_end", 32'(AckOut), 0);
    ReqIn = 4'b0000;
    tick();
    chk("drain2_valid", 32'(BusValid), 0);

    BusReady = 1'b0;
    ReqIn = 4'b0010;
    LastIn = 4'b0000;
    setData(1, 16'hBEEF);
    tick();
    chk("bp_owner", 32'(Owner), 1);
    chk("bp_ack_first", 32'(AckOut), 32'h2);
    tick();
    setData(1, 16'h1234);
    LastIn = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("bp_hold_data", 32'(BusData), 32'hBEEF);
      chk("bp_hold_valid", 32'(BusValid), 1);
      chk("bp_hold_ack", 32'(AckOut), 0);
      if (c < 3) tick();
    end
    BusReady = 1'b1;
    settle();
    chk("bp_release_ack", 32'(AckOut), 32'h2);
    tick();
    chk("bp_next_data", 32'(BusData), 32'h1234);
    chk("bp_next_busy", 32'(Busy), 0);
    ReqIn = 4'b0000;
    tick();
    chk("drain3_valid", 32'(BusValid), 0);

    ForceEn = 1'b1;
    ForceSel = 2'd3;
    ReqIn = 4'b1001;
    LastIn = 4'b1111;
    setData(3, 16'h00F3);
    tick();
    chk("force_owner", 32'(Owner), 3);
    chk("force_ack", 32'(AckOut), 32'h8);
    tick();
    chk("force_data", 32'(BusData), 32'h00F3);
    chk("force_busy_done", 32'(Busy), 0);
    ReqIn = 4'b0001;
    tick();
    chk("force_idle_busy", 32'(Busy), 0);
    chk("force_idle_owner", 32'(Owner), 3);
    tick();
    chk("force_idle_busy2", 32'(Busy), 0);
    chk("force_idle_ack", 32'(AckOut), 0);
    ForceEn = 1'b0;
    ReqIn = 4'b0000;
    tick();

    ReqIn = 4'b0001;
    LastIn = 4'b0000;
    setData(0, 16'h00B0);
    tick();
    chk("stall_owner", 32'(Owner), 0);
    tick();
    chk("stall_data0", 32'(BusData), 32'h00B0);
    ReqIn = 4'b0010;
    setData(0, 16'h00B1);
    settle();
    chk("stall_ack", 32'(AckOut), 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("stall_owner_hold", 32'(Owner), 0);
      chk("stall_busy", 32'(Busy), 1);
      chk("stall_data_hold", 32'(BusData), 32'h00B0);
      chk("stall_ack_hold", 32'(AckOut), 0);
    end
    ReqIn = 4'b0011;
    LastIn = 4'b0001;
    settle();
    chk("resume_ack", 32'(AckOut), 32'h1);
    tick();
    chk("resume_data", 32'(BusData), 32'h00B1);
    chk("resume_busy", 32'(Busy), 0);
    ReqIn = 4'b0000;
    tick();

    ReqIn = 4'b0100;
    LastIn = 4'b0000;
    setData(2, 16'h00C0);
    tick();
    chk("mid_owner", 32'(Owner), 2);
    tick();
    chk("mid_valid", 32'(BusValid), 1);
    Reset = 1'b1;
    tick();
    chk("mrst_valid", 32'(BusValid), 0);
    chk("mrst_busy", 32'(Busy), 0);
    chk("mrst_owner", 32'(Owner), 0);
    Reset = 1'b0;
    ReqIn = 4'b0011;
    LastIn = 4'b0011;
    tick();
    chk("post_rst_owner", 32'(Owner), 0);
    chk("post_rst_busy", 32'(Busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
